// File: rtl/lock_pkg.sv
// Shared types and constants for the push-button front end of the digital lock.
package lock_pkg;

    localparam int KEY_W               = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_MAX_FAILS       = 3;
    localparam int DEF_LOCKOUT_CYCLES  = 250000000;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_DEBOUNCE     = 3'd1,
        ST_ISSUE        = 3'd2,
        ST_WAIT_RELEASE = 3'd3,
        ST_LOCKOUT      = 3'd4
    } state_t;

    // Isolate the lowest set bit; lower key index wins simultaneous presses.
    function automatic logic [KEY_W-1:0] lowest_one_hot(input logic [KEY_W-1:0] v);
        return v & (~v + {{(KEY_W-1){1'b0}}, 1'b1});
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;

    // Metastability-settling pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/lock_key_controller.sv
// Debounces and arbitrates the lock push buttons into single-cycle one-hot key pulses,
// and blocks all keys for a timed lockout after too many consecutive failed attempts.
module lock_key_controller
    import lock_pkg::*;
#(
    parameter int  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int  MAX_FAILS       = DEF_MAX_FAILS,
    parameter int  LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    localparam int FW              = $clog2(MAX_FAILS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_n,
    input  logic             error_in,
    input  logic             locked_in,
    output logic [KEY_W-1:0] key_out,
    output logic             lockout,
    output logic [FW-1:0]    fail_count
);

    localparam int            CNT_MAX   = max_int(DEBOUNCE_CYCLES, LOCKOUT_CYCLES);
    localparam int            CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);

    logic [KEY_W-1:0] key_sync_n_s;
    logic [KEY_W-1:0] key_sync_s;
    logic             err_rise_s;
    logic             unlock_fall_s;
    logic             lockout_done_s;
    logic [FW-1:0]    fail_next_s;

    logic             prev_error_r;
    logic             prev_locked_r;
    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [KEY_W-1:0] cand_r;

    sync_2ff #(
        .W       (KEY_W),
        .RST_VAL (4'hF)
    ) u_key_sync (
        .clock (clock),
        .reset (reset),
        .d     (key_n),
        .q     (key_sync_n_s)
    );

    assign key_sync_s     = ~key_sync_n_s;
    assign err_rise_s     = error_in & ~prev_error_r;
    assign unlock_fall_s  = ~locked_in & prev_locked_r;
    assign lockout_done_s = (state_r == ST_LOCKOUT) && (cnt_r == LOCK_LAST);

    // Next failure count: lockout expiry and unlock clear it, errors outside lockout saturate-increment it.
    always_comb begin
        fail_next_s = fail_count;
        if (lockout_done_s || unlock_fall_s) begin
            fail_next_s = '0;
        end else if (err_rise_s && (state_r != ST_LOCKOUT) && (fail_count != FAIL_MAX)) begin
            fail_next_s = fail_count + FW'(1);
        end else begin
            fail_next_s = fail_count;
        end
    end

    // Edge-detect history and failure counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_error_r  <= 1'b0;
            prev_locked_r <= 1'b0;
            fail_count    <= '0;
        end else begin
            prev_error_r  <= error_in;
            prev_locked_r <= locked_in;
            fail_count    <= fail_next_s;
        end
    end

    // Key sequencing FSM with one counter shared between debounce, release and lockout timing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            cand_r  <= '0;
            key_out <= '0;
            lockout <= 1'b0;
        end else begin
            key_out <= '0;
            if ((fail_count == FAIL_MAX) && (state_r != ST_LOCKOUT)) begin
                // Lockout pre-empts everything, including a pulse about to be issued.
                state_r <= ST_LOCKOUT;
                cnt_r   <= '0;
                lockout <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (key_sync_s != '0) begin
                            cand_r  <= lowest_one_hot(key_sync_s);
                            cnt_r   <= '0;
                            state_r <= ST_DEBOUNCE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if ((key_sync_s & cand_r) == '0) begin
                            state_r <= ST_IDLE;
                        end else if (cnt_r == DEB_LAST) begin
                            state_r <= ST_ISSUE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_ISSUE: begin
                        key_out <= cand_r;
                        cnt_r   <= '0;
                        state_r <= ST_WAIT_RELEASE;
                    end
                    ST_WAIT_RELEASE: begin
                        if (key_sync_s != '0) begin
                            cnt_r <= '0;
                        end else if (cnt_r == DEB_LAST) begin
                            cnt_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_LOCKOUT: begin
                        if (lockout_done_s) begin
                            // Exit via release wait so a key held through lockout is never issued.
                            cnt_r   <= '0;
                            lockout <= 1'b0;
                            state_r <= ST_WAIT_RELEASE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        lockout <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_key_controller.sv
// Randomised and directed bench for lock_key_controller against a timestamp-based reference model.
module tb_lock_key_controller;

    localparam int D = 4;
    localparam int M = 3;
    localparam int L = 20;

    logic       clock;
    logic       reset;
    logic [3:0] key_n;
    logic       error_in;
    logic       locked_in;
    logic [3:0] key_out;
    logic       lockout;
    logic [1:0] fail_count;

    lock_key_controller #(
        .DEBOUNCE_CYCLES (D),
        .MAX_FAILS       (M),
        .LOCKOUT_CYCLES  (L)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .error_in   (error_in),
        .locked_in  (locked_in),
        .key_out    (key_out),
        .lockout    (lockout),
        .fail_count (fail_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int last_cyc = 0;
    int press_cyc = 0;
    int lock_len = 0;
    logic [3:0] last_val = 4'h0;

    // Reference model: phases with absolute-cycle timestamps instead of counters.
    typedef enum int {M_READY, M_QUALIFY, M_EMIT, M_QUIET, M_BLOCKED} mphase_t;
    mphase_t    ph = M_READY;
    int         cyc = 0;
    int         t_ref = 0;
    int         mfail = 0;
    logic [3:0] s1 = 4'hF;
    logic [3:0] s2 = 4'hF;
    logic [3:0] cand = 4'h0;
    logic [3:0] exp_key = 4'h0;
    bit         exp_lock = 1'b0;
    bit         pe = 1'b0;
    bit         pl = 1'b0;

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [3:0] ks;
        bit er, uf, was_blocked, done;
        cyc++;
        if (reset) begin
            ph = M_READY; s1 = 4'hF; s2 = 4'hF; pe = 1'b0; pl = 1'b0;
            mfail = 0; exp_key = 4'h0; exp_lock = 1'b0; cand = 4'h0; t_ref = cyc;
            return;
        end
        ks = ~s2;
        s2 = s1;
        s1 = key_n;
        er = error_in && !pe;
        uf = !locked_in && pl;
        pe = error_in;
        pl = locked_in;
        was_blocked = (ph == M_BLOCKED);
        done = 1'b0;
        exp_key = 4'h0;
        if (mfail == M && !was_blocked) begin
            ph = M_BLOCKED; t_ref = cyc; exp_lock = 1'b1;
        end else begin
            case (ph)
                M_READY:   if (ks != 4'h0) begin cand = lowest(ks); t_ref = cyc; ph = M_QUALIFY; end
                M_QUALIFY: if ((ks & cand) == 4'h0) ph = M_READY;
                           else if (cyc - t_ref == D) ph = M_EMIT;
                M_EMIT:    begin exp_key = cand; ph = M_QUIET; t_ref = cyc; end
                M_QUIET:   if (ks != 4'h0) t_ref = cyc;
                           else if (cyc - t_ref == D) ph = M_READY;
                M_BLOCKED: if (cyc - t_ref == L) begin ph = M_QUIET; t_ref = cyc; exp_lock = 1'b0; done = 1'b1; end
                default:   ph = M_READY;
            endcase
        end
        if (done || uf) mfail = 0;
        else if (er && !was_blocked && mfail < M) mfail++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("key_out", key_out, exp_key);
        check("lockout", lockout, exp_lock);
        check("fail_count", fail_count, mfail);
        check("key_out_onehot0", $onehot0(key_out), 1);
        if (key_out != 4'h0) begin
            pulse_cnt++;
            last_val = key_out;
            last_cyc = cyc;
        end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; key_n = 4'hF; error_in = 1'b0; locked_in = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("reset_key_out", key_out, 0);
        check("reset_lockout", lockout, 0);
        check("reset_fail", fail_count, 0);

        // Single press of key 1: one pulse, 7 cycles after the press is first sampled.
        pulse_cnt = 0;
        key_n = 4'b1101;
        press_cyc = cyc + 1;
        repeat (10) tick();
        key_n = 4'hF;
        repeat (12) tick();
        check("press_pulse_count", pulse_cnt, 1);
        check("press_pulse_value", last_val, 4'b0010);
        check("press_latency", last_cyc - press_cyc, 7);

        // Bounce shorter than the debounce window.
        pulse_cnt = 0;
        key_n = 4'b1110;
        repeat (2) tick();
        key_n = 4'hF;
        repeat (12) tick();
        check("bounce_no_pulse", pulse_cnt, 0);

        // Keys 0 and 3 together: only key 0 issued.
        pulse_cnt = 0;
        key_n = 4'b0110;
        repeat (12) tick();
        key_n = 4'hF;
        repeat (12) tick();
        check("simul_pulse_count", pulse_cnt, 1);
        check("simul_pulse_value", last_val, 4'b0001);

        // Three failures then lockout; presses inside lockout are swallowed.
        error_in = 1'b1; tick(); check("fail_1", fail_count, 1);
        error_in = 1'b0; tick();
        error_in = 1'b1; tick(); check("fail_2", fail_count, 2);
        error_in = 1'b0; tick();
        error_in = 1'b1; tick(); check("fail_3", fail_count, 3);
        check("lockout_not_yet", lockout, 0);
        error_in = 1'b0;
        key_n = 4'b1110;
        pulse_cnt = 0;
        tick();
        check("lockout_entry", lockout, 1);
        lock_len = 1;
        for (int i = 0; i < 40 && lockout; i++) begin
            if (i == 8) key_n = 4'hF;
            tick();
            if (lockout) lock_len++;
        end
        key_n = 4'hF;
        check("lockout_end", lockout, 0);
        check("lockout_length", lock_len, L);
        check("lockout_fail_clear", fail_count, 0);
        repeat (8) tick();
        check("lockout_no_pulse", pulse_cnt, 0);

        // Unlock clears failures, including when coincident with an error edge.
        locked_in = 1'b1; tick();
        error_in = 1'b1; tick(); error_in = 1'b0; tick();
        error_in = 1'b1; tick(); error_in = 1'b0; tick();
        check("unlock_pre", fail_count, 2);
        locked_in = 1'b0; tick();
        check("unlock_clear", fail_count, 0);
        locked_in = 1'b1; error_in = 1'b1; tick();
        check("unlock_pre2", fail_count, 1);
        error_in = 1'b0; tick();
        error_in = 1'b1; locked_in = 1'b0; tick();
        check("unlock_coincident", fail_count, 0);
        error_in = 1'b0; tick();

        // Reset during debounce.
        pulse_cnt = 0;
        key_n = 4'b0111;
        repeat (4) tick();
        reset = 1'b1; key_n = 4'hF; tick();
        check("rst_deb_key_out", key_out, 0);
        check("rst_deb_lockout", lockout, 0);
        check("rst_deb_fail", fail_count, 0);
        reset = 1'b0;
        repeat (12) tick();
        check("rst_deb_no_pulse", pulse_cnt, 0);

        // Reset during lockout.
        repeat (3) begin
            error_in = 1'b1; tick();
            error_in = 1'b0; tick();
        end
        repeat (5) tick();
        check("rst_lock_pre", lockout, 1);
        reset = 1'b1; tick();
        check("rst_lock_lockout", lockout, 0);
        check("rst_lock_fail", fail_count, 0);
        check("rst_lock_key_out", key_out, 0);
        reset = 1'b0;
        repeat (25) tick();
        check("rst_lock_stays_clear", lockout, 0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       key_n = 4'hF;
                    1:       key_n = ~(4'b0001 << $urandom_range(0, 3));
                    2:       key_n = 4'($urandom_range(0, 15));
                    default: key_n = 4'hF;
                endcase
            end
            if ($urandom_range(0, 29) == 0) error_in = ~error_in;
            if ($urandom_range(0, 79) == 0) locked_in = ~locked_in;
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
